drfm_sdram_master: RTL and testbench
====================================

Name: drfm_sdram_master

Overview:
Avalon-MM initiator that drives the SDRAM controller's bridge slave port (interface_* signals) for DRFM record and playback. In RECORD it writes a stream of 16-bit ADC samples to consecutive SDRAM words. In PLAY it issues pipelined reads and delivers the returned samples to the DAC path through a credit-limited FIFO. It sits between the sample datapath and the SDRAM controller, in the same clock domain.

Parameters:
ADDR_W, 25, word address width; matches interface_address
DATA_W, 16, sample/data width; matches interface_writedata/readdata
FIFO_DEPTH, 8, entries in each of the record and playback FIFOs; power of two, at least 2

Ports:
clk_clk  in  1  system clock
reset_reset_n  in  1  asynchronous active-low reset
start_record  in  1  one-cycle pulse; starts a record run (accepted only in IDLE)
start_playback  in  1  one-cycle pulse; starts a playback run (accepted only in IDLE)
abort  in  1  one-cycle pulse; terminates the current run
base_addr  in  ADDR_W  start word address, sampled at start
length  in  ADDR_W  number of words in the run, sampled at start
rec_data  in  DATA_W  record sample
rec_valid  in  1  rec_data valid this cycle; no backpressure
play_data  out  DATA_W  playback sample (FIFO head)
play_valid  out  1  play_data valid
play_ready  in  1  consumer accepts play_data
busy  out  1  high whenever the FSM is not in IDLE
done  out  1  one-cycle pulse on return to IDLE
rec_overflow  out  1  sticky; a sample arrived while the record FIFO was full
interface_address  out  ADDR_W  Avalon word address
interface_byteenable_n  out  2  active-low byte enables
interface_chipselect  out  1  command valid
interface_writedata  out  DATA_W  write data
interface_read_n  out  1  active-low read
interface_write_n  out  1  active-low write
interface_readdata  in  DATA_W  read data
interface_readdatavalid  in  1  read data strobe
interface_waitrequest  in  1  slave stall

Behaviour:
- Reset values:
  - chipselect=0, read_n=1, write_n=1, byteenable_n=2'b11, address=0, writedata=0
  - busy=0, done=0, play_valid=0, rec_overflow=0; FIFOs empty; pending=0
- Avalon handshake:
  - A command is accepted in a cycle when chipselect=1, read_n=0 or write_n=0 (never both), and waitrequest=0.
  - While waitrequest=1, address, writedata, byteenable_n, read_n and write_n are held stable.
  - During a command, byteenable_n=2'b00. When idle, byteenable_n=2'b11, read_n=write_n=1, chipselect=0.
  - A new command may be presented in the cycle after acceptance, giving back-to-back throughput of 1 word/cycle.
- Address: cur_addr loads base_addr at start and increments by 1 on each accepted command. It wraps modulo 2^ADDR_W (0x1FFFFFF -> 0).
- FSM states: IDLE, REC, PLAY, DRAIN, FLUSH.
- IDLE:
  - start_record -> REC; start_playback -> PLAY.
  - If both pulse together, REC wins.
  - If length=0 at start, go straight to FLUSH, which gives done one cycle later.
  - Start pulses arriving outside IDLE are ignored.
- REC:
  - Each rec_valid pushes rec_data into the record FIFO.
  - If the FIFO is full, the sample is dropped and rec_overflow is set. rec_overflow clears only at the next accepted start or on reset.
  - When the FIFO is non-empty and words remain, present a write with the FIFO head; pop on acceptance.
  - When remaining reaches 0 -> FLUSH. Samples arriving after the last accepted word are ignored and do not set overflow.
- PLAY:
  - Present a read when remaining>0 and (pending + fifo_count) < FIFO_DEPTH.
  - pending increments on read acceptance and decrements on readdatavalid. A read acceptance and a readdatavalid in the same cycle leave pending unchanged.
  - readdatavalid pushes readdata into the playback FIFO; by the credit rule this never overflows.
  - When remaining reaches 0 -> DRAIN.
- DRAIN: no new commands. Wait until pending=0 and the playback FIFO is empty, then -> FLUSH.
- FLUSH: clears both FIFOs, deasserts busy, pulses done, then -> IDLE.
- play_valid = playback FIFO non-empty. A pop happens when play_valid & play_ready.
- Readdata to play_data latency is at least 1 cycle when the FIFO was empty (registered FIFO).
- abort:
  - In REC or PLAY: finish any command currently held under waitrequest (it must not be withdrawn), then stop issuing commands.
  - REC then goes to FLUSH. PLAY then goes to DRAIN, but discards readdata instead of pushing it and flushes the playback FIFO immediately.
  - Ignored in IDLE.
- Asynchronous reset mid-run returns every register to its reset value immediately. Outstanding slave reads are not tracked across reset.

Test Plan:
- Record, no stall: base_addr=0x1FFFFFE, length=4, rec_valid on 4 consecutive cycles, waitrequest=0 -> 4 writes at addresses 0x1FFFFFE, 0x1FFFFFF, 0x0000000, 0x0000001 with matching data; done pulses once; rec_overflow=0.
- Record with stall: waitrequest=1 for 12 cycles during a 16-sample burst, FIFO_DEPTH=8 -> address and data held stable under stall; rec_overflow=1; exactly length words written, in order.
- Playback, slave read latency 3 and waitrequest=0: base_addr=0x100, length=20, play_ready=1 -> reads at 0x100..0x113; pending+fifo_count never exceeds 8; play_data order matches memory; done after the 20th pop.
- Playback backpressure: play_ready=0 for 30 cycles -> exactly 8 reads issued and then no further reads; traffic resumes when play_ready goes high.
- Abort while a read is held under waitrequest=1 -> command held until accepted, then no new commands; returned data is not presented on play_data; busy falls after pending=0; done pulses.
- start_record and start_playback pulse in the same cycle with length=0 -> REC is selected, no Avalon traffic, done 2 cycles after the start; a start pulse while busy is ignored.

Source files
------------

// File: rtl/drfm_sdram_master_if.sv
// Avalon-MM bundle between the DRFM sample master
// and the bridge slave port of the SDRAM controller.
interface drfm_sdram_master_if #(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] interface_address;
  logic [1:0]        interface_byteenable_n;
  logic              interface_chipselect;
  logic [DATA_W-1:0] interface_writedata;
  logic              interface_read_n;
  logic              interface_write_n;
  logic [DATA_W-1:0] interface_readdata;
  logic              interface_readdatavalid;
  logic              interface_waitrequest;

  modport master (
    output interface_address,
    output interface_byteenable_n,
    output interface_chipselect,
    output interface_writedata,
    output interface_read_n,
    output interface_write_n,
    input  interface_readdata,
    input  interface_readdatavalid,
    input  interface_waitrequest
  );

  modport slave (
    input  interface_address,
    input  interface_byteenable_n,
    input  interface_chipselect,
    input  interface_writedata,
    input  interface_read_n,
    input  interface_write_n,
    output interface_readdata,
    output interface_readdatavalid,
    output interface_waitrequest
  );
endinterface

// File: rtl/drfm_sdram_master.sv
// DRFM record/playback Avalon-MM initiator: streams ADC samples
// to SDRAM and plays them back through a credit-limited FIFO.
module drfm_sdram_master #(
  parameter int ADDR_W     = 25,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              start_record,
  input  logic              start_playback,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic [DATA_W-1:0] rec_data,
  input  logic              rec_valid,
  output logic [DATA_W-1:0] play_data,
  output logic              play_valid,
  input  logic              play_ready,
  output logic              busy,
  output logic              done,
  output logic              rec_overflow,
  drfm_sdram_master_if.master avm
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] C1 = CW'(1);
  localparam logic [PW-1:0] P1 = PW'(1);
  localparam logic [ADDR_W-1:0] A1 = ADDR_W'(1);

  typedef enum logic [2:0] {
    IDLE, REC, PLAY, DRAIN, FLUSH
  } state_t;

  state_t state, state_nx;

  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] remaining;
  logic [CW-1:0]     pending;
  logic              held;
  logic              stopping;
  logic              discard;

  logic [DATA_W-1:0] rec_mem [FIFO_DEPTH];
  logic [PW-1:0]     rec_wp, rec_rp;
  logic [CW-1:0]     rec_cnt;
  logic [DATA_W-1:0] play_mem [FIFO_DEPTH];
  logic [PW-1:0]     play_wp, play_rp;
  logic [CW-1:0]     play_cnt;

  logic wreq, rdv;
  logic start, stop, can_issue, cs, accept;
  logic is_rd, is_wr, rec_ok;
  logic rec_push, rec_drop, rec_pop;
  logic play_push, play_pop, play_flush;
  logic pend_inc, pend_dec;

  assign wreq  = avm.interface_waitrequest;
  assign rdv   = avm.interface_readdatavalid;
  assign is_wr = state == REC;
  assign is_rd = state == PLAY;
  assign start = state == IDLE
              && (start_record || start_playback);
  assign stop  = stopping
              || (abort && (is_wr || is_rd));

  always_comb begin
    can_issue = 1'b0;
    unique case (state)
      REC: can_issue = rec_cnt != '0
                    && remaining != '0;
      PLAY: can_issue = remaining != '0
                     && ({1'b0, pending} + {1'b0, play_cnt})
                        < {1'b0, DEPTH};
      default: can_issue = 1'b0;
    endcase
  end

  // A command stalled by waitrequest stays up even through abort.
  assign cs     = held || (can_issue && !stop);
  assign accept = cs && !wreq;

  assign avm.interface_chipselect   = cs;
  assign avm.interface_write_n      = !(cs && is_wr);
  assign avm.interface_read_n       = !(cs && is_rd);
  assign avm.interface_byteenable_n = cs ? 2'b00 : 2'b11;
  assign avm.interface_address      = cs ? cur_addr : '0;
  assign avm.interface_writedata    =
    (cs && is_wr) ? rec_mem[rec_rp] : '0;

  assign rec_ok   = is_wr && rec_valid
                 && remaining != '0 && !stop;
  assign rec_push = rec_ok && rec_cnt != DEPTH;
  assign rec_drop = rec_ok && rec_cnt == DEPTH;
  assign rec_pop  = accept && is_wr;

  assign play_flush = state == FLUSH
                   || (is_rd && abort);
  assign play_push  = rdv && !discard && !play_flush
                   && (is_rd || state == DRAIN);
  assign play_valid = play_cnt != '0;
  assign play_pop   = play_valid && play_ready;
  assign play_data  = play_mem[play_rp];

  assign pend_inc = accept && is_rd;
  assign pend_dec = rdv && pending != '0;

  assign busy = state != IDLE;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (start)
          state_nx = (length == '0) ? FLUSH
                   : start_record ? REC : PLAY;
      REC:
        if (remaining == '0
            || (stop && !(cs && wreq)))
          state_nx = FLUSH;
      PLAY:
        if (remaining == '0
            || (stop && !(cs && wreq)))
          state_nx = DRAIN;
      DRAIN:
        if (pending == '0 && play_cnt == '0)
          state_nx = FLUSH;
      FLUSH: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state        <= IDLE;
      held         <= 1'b0;
      done         <= 1'b0;
      cur_addr     <= '0;
      remaining    <= '0;
      pending      <= '0;
      stopping     <= 1'b0;
      discard      <= 1'b0;
      rec_overflow <= 1'b0;
    end else begin
      state <= state_nx;
      held  <= cs && wreq;
      done  <= state == FLUSH;
      if (start) begin
        cur_addr     <= base_addr;
        remaining    <= length;
        stopping     <= 1'b0;
        discard      <= 1'b0;
        rec_overflow <= 1'b0;
      end else begin
        if (accept) begin
          cur_addr  <= cur_addr + A1;
          remaining <= remaining - A1;
        end
        if (stop) stopping <= 1'b1;
        if (is_rd && abort) discard <= 1'b1;
        if (rec_drop) rec_overflow <= 1'b1;
      end
      if (pend_inc && !pend_dec)
        pending <= pending + C1;
      else if (!pend_inc && pend_dec)
        pending <= pending - C1;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rec_wp  <= '0;
      rec_rp  <= '0;
      rec_cnt <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        rec_mem[i] <= '0;
    end else if (state == FLUSH) begin
      rec_wp  <= '0;
      rec_rp  <= '0;
      rec_cnt <= '0;
    end else begin
      if (rec_push) begin
        rec_mem[rec_wp] <= rec_data;
        rec_wp <= rec_wp + P1;
      end
      if (rec_pop) rec_rp <= rec_rp + P1;
      rec_cnt <= rec_cnt + CW'(rec_push)
                         - CW'(rec_pop);
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      play_wp  <= '0;
      play_rp  <= '0;
      play_cnt <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        play_mem[i] <= '0;
    end else if (play_flush) begin
      play_wp  <= '0;
      play_rp  <= '0;
      play_cnt <= '0;
    end else begin
      if (play_push) begin
        play_mem[play_wp] <= avm.interface_readdata;
        play_wp <= play_wp + P1;
      end
      if (play_pop) play_rp <= play_rp + P1;
      play_cnt <= play_cnt + CW'(play_push)
                           - CW'(play_pop);
    end
  end
endmodule

// File: tb/tb_drfm_sdram_master.sv
// Scoreboard bench for drfm_sdram_master: SDRAM slave model,
// expected-traffic queues and a negedge monitor.
module tb_drfm_sdram_master;
  localparam int AW = 25;
  localparam int DW = 16;
  localparam int DEPTH = 8;
  localparam int LAT = 3;

  logic clk_clk = 1'b0;
  logic reset_reset_n = 1'b0;
  logic start_record = 1'b0;
  logic start_playback = 1'b0;
  logic abort = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] length = '0;
  logic [DW-1:0] rec_data = '0;
  logic rec_valid = 1'b0;
  logic [DW-1:0] play_data;
  logic play_valid;
  logic play_ready = 1'b0;
  logic busy, done, rec_overflow;

  drfm_sdram_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  drfm_sdram_master #(
    .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_clk(clk_clk),
    .reset_reset_n(reset_reset_n),
    .start_record(start_record),
    .start_playback(start_playback),
    .abort(abort),
    .base_addr(base_addr),
    .length(length),
    .rec_data(rec_data),
    .rec_valid(rec_valid),
    .play_data(play_data),
    .play_valid(play_valid),
    .play_ready(play_ready),
    .busy(busy),
    .done(done),
    .rec_overflow(rec_overflow),
    .avm(bus)
  );

  always #5 clk_clk = ~clk_clk;

  int n_tests = 0;
  int n_fail = 0;

  task automatic check(input string name,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: unexpected event at cycle", name);
  endtask

  // SDRAM contents: a fixed function of the word address.
  function automatic logic [DW-1:0] mem_at(input logic [AW-1:0] a);
    return a[15:0] ^ {a[24:16], 7'h35} ^ 16'h1D3B;
  endfunction

  typedef struct {
    int due;
    logic [DW-1:0] data;
  } rsp_t;

  rsp_t rsp_q[$];
  logic [AW+DW-1:0] exp_wr[$];
  logic [AW-1:0] exp_rd[$];
  logic [DW-1:0] exp_play[$];

  int cyc = 0;
  int wait_pct = 0;
  int ready_pct = 100;
  int force_wait = 0;
  bit wait_hold = 1'b0;

  // Slave and consumer model: drives waitrequest, returns data LAT cycles after acceptance.
  initial begin
    bus.interface_waitrequest = 1'b0;
    bus.interface_readdatavalid = 1'b0;
    bus.interface_readdata = '0;
  end

  always @(posedge clk_clk) begin
    cyc = cyc + 1;
    #1;
    bus.interface_waitrequest = wait_hold || force_wait > 0
      || (int'($urandom_range(99)) < wait_pct);
    if (force_wait > 0) force_wait--;
    play_ready = int'($urandom_range(99)) < ready_pct;
    if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
      bus.interface_readdatavalid = 1'b1;
      bus.interface_readdata = rsp_q[0].data;
      void'(rsp_q.pop_front());
    end else begin
      bus.interface_readdatavalid = 1'b0;
      bus.interface_readdata = DW'($urandom);
    end
  end

  int rd_acc = 0;
  int pops = 0;
  int rdv_seen = 0;
  int max_occ = 0;
  int done_cnt = 0;
  int last_rdv = 0;
  int busy_fall = 0;
  bit prev_busy = 1'b0;
  bit prev_hold = 1'b0;
  logic [45:0] prev_vec = '0;
  logic [45:0] cur_vec;
  logic acc;
  logic [AW+DW-1:0] wexp;

  always @(negedge clk_clk) begin
    if (reset_reset_n) begin
      cur_vec = {bus.interface_chipselect,
                 bus.interface_read_n,
                 bus.interface_write_n,
                 bus.interface_byteenable_n,
                 bus.interface_address,
                 bus.interface_writedata};
      acc = bus.interface_chipselect && !bus.interface_waitrequest;
      if (prev_hold) check("hold_stable", cur_vec, prev_vec);
      if (bus.interface_chipselect)
        check("cmd_form",
              {bus.interface_byteenable_n,
               bus.interface_read_n ^ bus.interface_write_n},
              3'b001);
      if (acc && !bus.interface_write_n) begin
        if (exp_wr.size() == 0) fail_now("unexpected_write");
        else begin
          wexp = exp_wr.pop_front();
          check("write_addr_data",
                {bus.interface_address, bus.interface_writedata},
                wexp);
        end
      end
      if (acc && !bus.interface_read_n) begin
        rd_acc++;
        rsp_q.push_back('{cyc + LAT, mem_at(bus.interface_address)});
        if (exp_rd.size() == 0) fail_now("unexpected_read");
        else check("read_addr", bus.interface_address,
                   exp_rd.pop_front());
      end
      if (bus.interface_readdatavalid) begin
        rdv_seen++;
        last_rdv = cyc;
      end
      if (play_valid && play_ready) begin
        pops++;
        if (exp_play.size() == 0) fail_now("unexpected_play");
        else check("play_data", play_data, exp_play.pop_front());
      end
      if (rd_acc - pops > max_occ) max_occ = rd_acc - pops;
      if (done) done_cnt++;
      if (prev_busy && !busy) busy_fall = cyc;
      prev_busy = busy;
      prev_hold = bus.interface_chipselect && bus.interface_waitrequest;
      prev_vec = cur_vec;
    end else begin
      prev_hold = 1'b0;
      prev_busy = 1'b0;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_clk);
      #1;
    end
  endtask

  task automatic clear_run();
    rd_acc = 0;
    pops = 0;
    rdv_seen = 0;
    max_occ = 0;
  endtask

  task automatic wait_done(input string name, input int limit);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < limit) begin
      tick();
      n++;
    end
    check({name, "_done_seen"}, done_cnt != d0, 1);
    tick(3);
    check({name, "_done_once"}, done_cnt - d0, 1);
    check({name, "_idle"}, busy, 0);
  endtask

  task automatic run_record(input string name,
                            input logic [AW-1:0] base,
                            input int len, input int nsamp,
                            input int gapmax, input int stall,
                            input int nexp, input bit exp_ovf);
    logic [DW-1:0] s;
    clear_run();
    base_addr = base;
    length = AW'(len);
    force_wait = stall;
    start_record = 1'b1;
    tick();
    start_record = 1'b0;
    for (int i = 0; i < nsamp; i++) begin
      s = DW'($urandom);
      rec_data = s;
      rec_valid = 1'b1;
      if (i < nexp) exp_wr.push_back({base + AW'(i), s});
      tick();
      rec_valid = 1'b0;
      if (gapmax > 0) tick(int'($urandom_range(gapmax)));
    end
    wait_done(name, 500);
    check({name, "_overflow"}, rec_overflow, exp_ovf);
    check({name, "_writes_left"}, exp_wr.size(), 0);
    exp_wr.delete();
  endtask

  task automatic run_play(input string name,
                          input logic [AW-1:0] base,
                          input int len, input bit bp_test,
                          input bit poke_start);
    clear_run();
    for (int i = 0; i < len; i++) begin
      exp_rd.push_back(base + AW'(i));
      exp_play.push_back(mem_at(base + AW'(i)));
    end
    base_addr = base;
    length = AW'(len);
    start_playback = 1'b1;
    tick();
    start_playback = 1'b0;
    if (bp_test) begin
      tick(30);
      check({name, "_reads_under_bp"}, rd_acc, DEPTH);
      check({name, "_valid_under_bp"}, play_valid, 1);
      ready_pct = 100;
    end
    if (poke_start) begin
      tick(4);
      length = AW'(3);
      start_record = 1'b1;
      tick();
      start_record = 1'b0;
      check({name, "_busy_kept"}, busy, 1);
    end
    wait_done(name, 1000);
    check({name, "_pops"}, pops, len);
    check({name, "_credit"}, max_occ <= DEPTH, 1);
    check({name, "_reads_left"}, exp_rd.size(), 0);
    check({name, "_play_left"}, exp_play.size(), 0);
    exp_rd.delete();
    exp_play.delete();
  endtask

  initial begin
    tick(3);
    check("rst_cmd",
          {bus.interface_chipselect, bus.interface_read_n,
           bus.interface_write_n, bus.interface_byteenable_n},
          5'b01111);
    check("rst_addr", bus.interface_address, 0);
    check("rst_wdata", bus.interface_writedata, 0);
    check("rst_status", {busy, done, play_valid, rec_overflow}, 0);
    reset_reset_n = 1'b1;
    tick(2);

    run_record("rec_wrap", 25'h1FFFFFE, 4, 4, 0, 0, 4, 1'b0);

    // Stall keeps the first eight samples; the rest of the burst overflows.
    run_record("rec_stall", AW'($urandom), 8, 16, 0, 12, 8, 1'b1);

    wait_pct = 30;
    for (int k = 0; k < 4; k++) begin
      int len = int'($urandom_range(1, DEPTH));
      run_record("rec_rand", AW'($urandom), len, len, 2, 0, len, 1'b0);
    end
    wait_pct = 0;

    ready_pct = 100;
    run_play("play_lat3", 25'h100, 20, 1'b0, 1'b1);
    check("ovf_cleared", rec_overflow, 0);

    ready_pct = 0;
    run_play("play_bp", AW'($urandom), 20, 1'b1, 1'b0);

    wait_pct = 25;
    ready_pct = 70;
    for (int k = 0; k < 4; k++)
      run_play("play_rand", AW'($urandom),
               int'($urandom_range(1, 24)), 1'b0, 1'b0);
    wait_pct = 0;
    ready_pct = 100;

    clear_run();
    wait_hold = 1'b1;
    exp_rd.push_back(25'h40);
    base_addr = 25'h40;
    length = AW'(10);
    start_playback = 1'b1;
    tick();
    start_playback = 1'b0;
    tick(3);
    check("abort_held_read",
          {bus.interface_chipselect, bus.interface_read_n}, 2'b10);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick(3);
    check("abort_still_held", bus.interface_chipselect, 1);
    wait_hold = 1'b0;
    wait_done("abort", 200);
    check("abort_reads", rd_acc, 1);
    check("abort_rdv", rdv_seen, 1);
    check("abort_busy_after_rdv", busy_fall > last_rdv, 1);
    exp_rd.delete();

    base_addr = 25'h77;
    length = '0;
    start_record = 1'b1;
    start_playback = 1'b1;
    tick();
    start_record = 1'b0;
    start_playback = 1'b0;
    check("zero_len_c1", {busy, done}, 2'b10);
    tick();
    check("zero_len_c2", {busy, done}, 2'b01);
    tick(2);

    clear_run();
    base_addr = 25'h200;
    length = AW'(16);
    for (int i = 0; i < 16; i++) begin
      exp_rd.push_back(25'h200 + AW'(i));
      exp_play.push_back(mem_at(25'h200 + AW'(i)));
    end
    start_playback = 1'b1;
    tick();
    start_playback = 1'b0;
    tick(5);
    #2;
    reset_reset_n = 1'b0;
    #1;
    check("async_rst",
          {busy, play_valid, bus.interface_chipselect,
           bus.interface_read_n},
          4'b0001);
    rsp_q.delete();
    exp_rd.delete();
    exp_play.delete();
    tick(2);
    reset_reset_n = 1'b1;
    tick(3);
    check("post_rst_idle", {busy, bus.interface_chipselect}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
